// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared types and constants for the serializer feeding the
//            101/110 sequence detector.
// Revision : 1.0
// ============================================================================
package seq_det_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int WORDCNT_W = 16;

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : seq_hold_buf
// Brief    : One-entry holding register; cleared by reset, push loads, pop empties.
// Revision : 1.0
// ============================================================================
module seq_hold_buf
   import seq_det_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_push,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Push and pop are mutually exclusive: push needs empty, pop needs full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_push) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Brief    : Parallel-to-serial feeder with a one-word holding buffer for
//            gap-free streaming into the 101/110 detector.
// Revision : 1.0
// ============================================================================
module seq_bit_serializer
   import seq_det_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [WIDTH-1:0]     s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 ser_out,
   output logic                 ser_valid,
   output logic                 ser_last,
   output logic                 busy,
   output logic [WORDCNT_W-1:0] words_sent
);

   localparam int               CNT_W  = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       r_shift;
   logic [WIDTH-1:0]       w_shifted;
   logic                   w_head;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [WORDCNT_W-1:0]   r_words_sent;
   logic                   w_hold_valid;
   logic [WIDTH-1:0]       w_hold_data;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_load_in;
   logic                   w_push;
   logic                   w_pop;

   // s_ready depends only on registered hold state.
   assign w_accept  = s_valid && !w_hold_valid;
   assign w_last    = (r_state == SHIFT) && (r_bit_cnt == c_LAST);
   assign w_load_in = w_accept && ((r_state == IDLE) || w_last);
   assign w_push    = w_accept && !w_load_in;
   assign w_pop     = w_last && w_hold_valid;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_head    = r_shift[WIDTH-1];
         assign w_shifted = {r_shift[WIDTH-2:0], IDLE_BIT};
      end else begin : g_lsb_first
         assign w_head    = r_shift[0];
         assign w_shifted = {IDLE_BIT, r_shift[WIDTH-1:1]};
      end
   endgenerate

   seq_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk     (clk),
      .rstn    (rstn),
      .i_data  (s_data),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .o_valid (w_hold_valid),
      .o_data  (w_hold_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SHIFT;
         SHIFT:   if (w_last && !w_hold_valid && !w_accept) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready   = !w_hold_valid;
      ser_valid = (r_state == SHIFT);
      ser_last  = w_last;
      ser_out   = (r_state == SHIFT) ? w_head : IDLE_BIT;
      busy      = (r_state == SHIFT) || w_hold_valid;
   end

   // Next word (fresh or held) replaces the shift reg on the last-bit edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_words_sent <= '0;
      end else begin
         if (w_load_in) begin
            r_shift   <= s_data;
            r_bit_cnt <= '0;
         end else if (w_pop) begin
            r_shift   <= w_hold_data;
            r_bit_cnt <= '0;
         end else if (r_state == SHIFT) begin
            r_shift   <= w_shifted;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
         end
         if (w_last) begin
            r_words_sent <= r_words_sent + 1'b1;
         end
      end
   end

   assign words_sent = r_words_sent;

endmodule
`default_nettype wire
